// File: rtl/pad_cfg_bank.sv
// pad_cfg_bank: pad configuration shadow/active register bank with input synchronisers.
//   clk, rst                       core clock, synchronous active-high reset
//   cfg_valid/ready/write/addr/wdata  config request port (valid/ready handshake)
//   cfg_rdata, cfg_rvalid          read return, one cycle after an accepted read
//   cfg_commit, cfg_dirty          shadow -> active copy pulse, shadow-modified flag
//   core_out -> bidir_out          combinational drive-data passthrough
//   bidir_oe/cs/sl/ie/pu/pd        active bidir pad controls
//   input_pu/pd                    active input pad controls
//   *_pad_in -> *_in_sync          raw pad inputs through a SYNC_STAGES flop chain
module pad_cfg_bank #(
    parameter int NUM_INPUT_PADS = 12,
    parameter int NUM_BIDIR_PADS = 40,
    parameter int SYNC_STAGES    = 2,
    parameter int ADDR_W         = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic                      cfg_write,
    input  logic [ADDR_W-1:0]         cfg_addr,
    input  logic [7:0]                cfg_wdata,
    output logic [7:0]                cfg_rdata,
    output logic                      cfg_rvalid,
    input  logic                      cfg_commit,
    output logic                      cfg_dirty,
    input  logic [NUM_BIDIR_PADS-1:0] core_out,
    output logic [NUM_BIDIR_PADS-1:0] bidir_out,
    output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
    output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
    output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
    output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
    output logic [NUM_INPUT_PADS-1:0] input_pu,
    output logic [NUM_INPUT_PADS-1:0] input_pd,
    input  logic [NUM_BIDIR_PADS-1:0] bidir_pad_in,
    input  logic [NUM_INPUT_PADS-1:0] input_pad_in,
    output logic [NUM_BIDIR_PADS-1:0] bidir_in_sync,
    output logic [NUM_INPUT_PADS-1:0] input_in_sync
);
    localparam int NB = NUM_BIDIR_PADS;
    localparam int NI = NUM_INPUT_PADS;
    localparam int NP = NB + NI;
    typedef enum logic {IDLE, RDRET} state_t;
    state_t state;
    logic [7:0] shadow [NP];
    logic [SYNC_STAGES-1:0][NB-1:0] bsync;
    logic [SYNC_STAGES-1:0][NI-1:0] isync;
    logic in_range, is_bidir, acc, rd_acc, wr_ok;
    // one extra address bit so NP == 2**ADDR_W still compares correctly
    assign in_range = {1'b0, cfg_addr} < (ADDR_W+1)'(NP);
    assign is_bidir = {1'b0, cfg_addr} < (ADDR_W+1)'(NB);
    assign acc = cfg_valid & cfg_ready;
    assign rd_acc = acc & ~cfg_write & (state == IDLE);
    assign wr_ok = acc & cfg_write & in_range;
    assign bidir_out = core_out;
    assign bidir_in_sync = bsync[SYNC_STAGES-1];
    assign input_in_sync = isync[SYNC_STAGES-1];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cfg_ready <= 1'b0;
            cfg_rvalid <= 1'b0;
            cfg_rdata <= 8'h00;
        end else begin
            state <= rd_acc ? RDRET : IDLE;
            cfg_ready <= ~rd_acc;
            cfg_rvalid <= rd_acc;
            if (rd_acc) cfg_rdata <= in_range ? shadow[cfg_addr] : 8'h00;
        end
    end
    // active copies the pre-edge shadow, so a same-cycle write stays shadow-only
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NP; i++) shadow[i] <= i < NB ? 8'h08 : 8'h00;
            bidir_oe <= '0;
            bidir_cs <= '0;
            bidir_sl <= '0;
            bidir_ie <= '1;
            bidir_pu <= '0;
            bidir_pd <= '0;
            input_pu <= '0;
            input_pd <= '0;
            cfg_dirty <= 1'b0;
        end else begin
            if (wr_ok) shadow[cfg_addr] <= is_bidir ? cfg_wdata : cfg_wdata & 8'h30;
            if (cfg_commit) begin
                // PU wins a PU/PD conflict
                for (int i = 0; i < NB; i++) begin
                    bidir_oe[i] <= shadow[i][0];
                    bidir_cs[i] <= shadow[i][1];
                    bidir_sl[i] <= shadow[i][2];
                    bidir_ie[i] <= shadow[i][3];
                    bidir_pu[i] <= shadow[i][4];
                    bidir_pd[i] <= shadow[i][5] & ~shadow[i][4];
                end
                for (int i = 0; i < NI; i++) begin
                    input_pu[i] <= shadow[NB+i][4];
                    input_pd[i] <= shadow[NB+i][5] & ~shadow[NB+i][4];
                end
            end
            cfg_dirty <= wr_ok ? 1'b1 : cfg_commit ? 1'b0 : cfg_dirty;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bsync <= '0;
            isync <= '0;
        end else begin
            bsync <= {bsync[SYNC_STAGES-2:0], bidir_pad_in};
            isync <= {isync[SYNC_STAGES-2:0], input_pad_in};
        end
    end
endmodule

// File: tb/tb_pad_cfg_bank.sv
// tb_pad_cfg_bank: randomized + directed bench for pad_cfg_bank against a transaction-level model.
module tb_pad_cfg_bank;
    localparam int NB = 40;
    localparam int NI = 12;
    localparam int NP = NB + NI;
    localparam int S  = 2;
    logic clk = 0;
    logic rst, cfg_valid, cfg_ready, cfg_write, cfg_rvalid, cfg_commit, cfg_dirty;
    logic [5:0] cfg_addr;
    logic [7:0] cfg_wdata, cfg_rdata;
    logic [NB-1:0] core_out, bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
    logic [NB-1:0] bidir_pad_in, bidir_in_sync;
    logic [NI-1:0] input_pu, input_pd, input_pad_in, input_in_sync;
    int n_tests = 0;
    int n_fail = 0;
    // reference model state
    logic [7:0] m_sh [NP];
    logic [7:0] m_act [NP];
    logic m_dirty, m_ready, m_rvalid;
    logic [7:0] m_rdata;
    logic [NB-1:0] m_bh [S];
    logic [NI-1:0] m_ih [S];

    always #5 clk = ~clk;

    pad_cfg_bank #(.NUM_INPUT_PADS(NI), .NUM_BIDIR_PADS(NB), .SYNC_STAGES(S), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_write(cfg_write),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
        .cfg_commit(cfg_commit), .cfg_dirty(cfg_dirty), .core_out(core_out), .bidir_out(bidir_out),
        .bidir_oe(bidir_oe), .bidir_cs(bidir_cs), .bidir_sl(bidir_sl), .bidir_ie(bidir_ie),
        .bidir_pu(bidir_pu), .bidir_pd(bidir_pd), .input_pu(input_pu), .input_pd(input_pd),
        .bidir_pad_in(bidir_pad_in), .input_pad_in(input_pad_in),
        .bidir_in_sync(bidir_in_sync), .input_in_sync(input_in_sync)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [NB-1:0] e_oe, e_cs, e_sl, e_ie, e_pu, e_pd;
        logic [NI-1:0] e_ipu, e_ipd;
        for (int i = 0; i < NB; i++) begin
            e_oe[i] = m_act[i][0];
            e_cs[i] = m_act[i][1];
            e_sl[i] = m_act[i][2];
            e_ie[i] = m_act[i][3];
            e_pu[i] = m_act[i][4];
            e_pd[i] = m_act[i][5] && !m_act[i][4];
        end
        for (int i = 0; i < NI; i++) begin
            e_ipu[i] = m_act[NB+i][4];
            e_ipd[i] = m_act[NB+i][5] && !m_act[NB+i][4];
        end
        chk("ready", cfg_ready, m_ready);
        chk("rvalid", cfg_rvalid, m_rvalid);
        if (m_rvalid) chk("rdata", cfg_rdata, m_rdata);
        chk("dirty", cfg_dirty, m_dirty);
        chk("oe", bidir_oe, e_oe);
        chk("cs", bidir_cs, e_cs);
        chk("sl", bidir_sl, e_sl);
        chk("ie", bidir_ie, e_ie);
        chk("pu", bidir_pu, e_pu);
        chk("pd", bidir_pd, e_pd);
        chk("input_pu", input_pu, e_ipu);
        chk("input_pd", input_pd, e_ipd);
        chk("bidir_sync", bidir_in_sync, m_bh[S-1]);
        chk("input_sync", input_in_sync, m_ih[S-1]);
        chk("bidir_out", bidir_out, core_out);
    endtask

    // apply one cycle of inputs, advance the model by one edge, then check
    task automatic cyc(input bit r, input bit v, input bit w, input logic [5:0] a,
                       input logic [7:0] d, input bit c);
        bit acc, rd;
        rst = r; cfg_valid = v; cfg_write = w; cfg_addr = a; cfg_wdata = d; cfg_commit = c;
        bidir_pad_in = NB'({$urandom(), $urandom()});
        input_pad_in = NI'($urandom());
        if (r) begin
            for (int i = 0; i < NP; i++) begin
                m_sh[i] = i < NB ? 8'h08 : 8'h00;
                m_act[i] = m_sh[i];
            end
            for (int k = 0; k < S; k++) begin
                m_bh[k] = '0;
                m_ih[k] = '0;
            end
            m_dirty = 0; m_ready = 0; m_rvalid = 0;
        end else begin
            acc = v && m_ready;
            rd = acc && !w;
            if (rd) m_rdata = a < NP ? m_sh[a] : 8'h00;
            m_rvalid = rd;
            m_ready = !rd;
            if (c) for (int i = 0; i < NP; i++) m_act[i] = m_sh[i];
            if (acc && w && a < NP) begin
                m_sh[a] = a < NB ? d : (d & 8'h30);
                m_dirty = 1;
            end else if (c) m_dirty = 0;
            for (int k = S - 1; k > 0; k--) begin
                m_bh[k] = m_bh[k-1];
                m_ih[k] = m_ih[k-1];
            end
            m_bh[0] = bidir_pad_in;
            m_ih[0] = input_pad_in;
        end
        @(posedge clk);
        #1;
        core_out = NB'({$urandom(), $urandom()});
        check_all();
    endtask

    task automatic idle(); cyc(0, 0, 0, 6'd0, 8'h00, 0); endtask

    initial begin
        core_out = '0;
        repeat (3) cyc(1, 0, 0, 6'd0, 8'h00, 0);
        chk("reset_ie_all", bidir_ie, {NB{1'b1}});
        chk("reset_ready_low", cfg_ready, 1'b0);
        idle();
        chk("ready_after_rst", cfg_ready, 1'b1);
        cyc(0, 1, 1, 6'd3, 8'h0B, 0);
        idle();
        chk("oe3_before_commit", bidir_oe[3], 1'b0);
        chk("dirty_after_write", cfg_dirty, 1'b1);
        cyc(0, 0, 0, 6'd0, 8'h00, 1);
        chk("oe3_after_commit", {bidir_oe[3], bidir_cs[3], bidir_ie[3], cfg_dirty}, 4'b1110);
        cyc(0, 1, 0, 6'd3, 8'h00, 0);
        chk("read3", {cfg_rvalid, cfg_ready, cfg_rdata}, {2'b10, 8'h0B});
        idle();
        cyc(0, 1, 1, 6'd40, 8'h30, 0);
        cyc(0, 0, 0, 6'd0, 8'h00, 1);
        chk("input_pupd0", {input_pu[0], input_pd[0]}, 2'b10);
        cyc(0, 1, 0, 6'd40, 8'h00, 0);
        chk("read40", cfg_rdata, 8'h30);
        idle();
        cyc(0, 1, 1, 6'd41, 8'hFF, 0);
        cyc(0, 1, 0, 6'd41, 8'h00, 0);
        chk("read41_masked", cfg_rdata, 8'h30);
        cyc(0, 0, 0, 6'd0, 8'h00, 1);
        cyc(0, 1, 1, 6'd63, 8'hFF, 0);
        chk("oor_write_no_dirty", cfg_dirty, 1'b0);
        cyc(0, 1, 0, 6'd63, 8'h00, 0);
        chk("read63", {cfg_rvalid, cfg_rdata}, {1'b1, 8'h00});
        idle();
        cyc(0, 1, 1, 6'd5, 8'h01, 1);
        chk("oe5_same_cycle", {bidir_oe[5], cfg_dirty}, 2'b01);
        cyc(0, 0, 0, 6'd0, 8'h00, 1);
        chk("oe5_second_commit", bidir_oe[5], 1'b1);
        cyc(0, 1, 1, 6'd9, 8'h30, 0);
        cyc(0, 1, 0, 6'd9, 8'h00, 1);
        chk("conflict_pu_wins", {bidir_pu[9], bidir_pd[9], cfg_rdata}, {2'b10, 8'h30});
        idle();
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] a;
            a = $urandom_range(0, 9) == 0 ? 6'd63 - 6'($urandom_range(0, 11)) : 6'($urandom_range(0, NP - 1));
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                a, 8'($urandom()), $urandom_range(0, 7) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
